ppg_phase_sequencer: RTL
========================

# ppg_phase_sequencer

- Time-multiplexes the RED and IR LEDs of the pulse-oximeter front end once per-channel settings are known.
- Applies each channel's DC compensation and PGA gain to the shared analog chain at every phase switch.
- Discards settling samples, averages the remaining ADC samples per phase, and publishes per-channel values with valid strobes and saturation flags.
- Sits between the settings-search controller (which supplies `cfg_*`) and the downstream SpO2/heart-rate processing.

## Interface
- `SETTLE`, default 2: samples discarded at the start of each phase.
- `AVG_LOG2`, default 3: log2 of the number of averaged samples per phase. Phase length `PLEN = SETTLE + 2^AVG_LOG2` (default 10).
- `CLK`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low. Clock is CLK.
- `enable`, in, 1: run the RED/IR sequence.
- `cfg_valid`, in, 1: one-cycle strobe that loads `cfg_*` into the shadow registers.
- `cfg_red_dc`, in, 7: DC compensation for RED.
- `cfg_ir_dc`, in, 7: DC compensation for IR.
- `cfg_red_pga`, in, 4: PGA gain for RED.
- `cfg_ir_pga`, in, 4: PGA gain for IR.
- `ADC`, in, 8: converter sample, valid every cycle.
- `LED_RED`, out, 1: RED LED enable.
- `LED_IR`, out, 1: IR LED enable.
- `DC_Comp`, out, 7: DC compensation applied to the analog chain.
- `PGA_Gain`, out, 4: PGA gain applied to the analog chain.
- `RED_ADC_Value`, out, 8: latest RED average.
- `IR_ADC_Value`, out, 8: latest IR average.
- `red_valid`, out, 1: one-cycle pulse when `RED_ADC_Value` updates.
- `ir_valid`, out, 1: one-cycle pulse when `IR_ADC_Value` updates.
- `pair_valid`, out, 1: one-cycle pulse when IR completes directly after a RED phase in the same run.
- `red_sat`, out, 1: RED window contained a sample of 0 or 255; updates with `red_valid`.
- `ir_sat`, out, 1: IR window contained a sample of 0 or 255; updates with `ir_valid`.

## Operation
- States:
  - IDLE: both LEDs off, `DC_Comp` = 64, `PGA_Gain` = 0.
  - RED: `LED_RED`=1, `LED_IR`=0, RED settings applied.
  - IR: `LED_IR`=1, `LED_RED`=0, IR settings applied.
- Transitions:
  - IDLE→RED when `enable`=1.
  - RED→IR at phase end.
  - IR→RED at phase end if `enable`=1, else IR→IDLE.
  - RED always completes and hands over to IR, even if `enable` drops during it.
- Both LEDs are never high in the same cycle.
- Shadow config:
  - `cfg_valid` writes all four shadow registers.
  - Shadow values reach `DC_Comp`/`PGA_Gain` only at a phase start, never mid-phase.
  - If `cfg_valid` coincides with a phase-start edge, the new values apply to the starting phase.
- Phase counter `pc` runs 0..PLEN-1 and resets to 0 at each phase start.
  - Samples with `pc` < SETTLE are ignored.
  - Samples with `pc` ≥ SETTLE are added to accumulator `acc`. `acc` is 8+AVG_LOG2 bits, cannot overflow, and needs no saturation.
  - Each counted sample equal to 0 or 255 sets the sticky saturation bit for the phase.
- Result: average = (acc + ADC at `pc`=PLEN-1) >> AVG_LOG2, truncating. At the phase end, `acc` and the saturation bit clear.
- `pair_valid` requires that the preceding RED phase belonged to the same run, i.e. the sequence did not pass through IDLE in between.
- Reset values:
  - LEDs 0, `DC_Comp` 64, `PGA_Gain` 0.
  - Both values 0; all valids and sat flags 0.
  - Shadow registers: dc 64, pga 0.
  - State IDLE, `pc` 0, `acc` 0.
- Reset mid-phase aborts the phase immediately, with no partial result published.

## Timing
- All outputs are registered.
- `enable` is sampled high in IDLE at edge E.
  - From E, `LED_RED`=1 and RED settings are on the outputs; this is `pc`=0.
- RED phase spans cycles E..E+PLEN-1.
  - The ADC sample is captured on the rising edge that ends each cycle.
  - The edge ending `pc`=PLEN-1 (edge E+PLEN) does three things:
    - switches to IR settings with `LED_IR`=1;
    - loads `RED_ADC_Value`;
    - pulses `red_valid` during the first IR cycle.
- Latency from last RED sample to `red_valid`: 1 cycle.
- Period of one full RED+IR pair: 2·PLEN cycles (20 by default).
- `pair_valid` is asserted in the same cycle as `ir_valid`.
- `enable` low at the end of IR: the LEDs go off on the same edge that publishes IR.

## Test plan
- Reset, then `enable`=1 with ADC held at 100 → `LED_RED` rises 1 cycle after `enable` is sampled; `red_valid` in cycle 11 with value 100; `ir_valid` and `pair_valid` in cycle 21 with IR value 100; LEDs never both high.
- ADC ramps 0,1,2,… from the RED phase start → RED value = (2+…+9)/8 = 5; settle samples 0 and 1 are excluded.
- Sample `cfg_valid` with red_dc=70/pga=5 at `pc`=4 of a RED phase → `DC_Comp` unchanged until the next RED phase start, then 70/5.
- ADC = 255 for one counted cycle only → average correct, no wrap; `red_sat`=1 for that phase only, cleared on the next RED result.
- Drop `enable` mid-RED → RED then IR phases complete, `pair_valid` pulses, state goes to IDLE with LEDs 0, `DC_Comp` 64.
- Assert `rst_n`=0 mid-IR → outputs go to reset values immediately with no `ir_valid`; after release with `enable`=1 the sequence restarts at RED `pc`=0.

Source files
------------

// File: rtl/ppg_phase_sequencer_if.sv
// Signal bundle between the settings controller / ADC and the RED/IR phase sequencer.
// The slave side is the sequencer; the master side supplies run control, settings and samples.
interface ppg_phase_sequencer_if;
  logic       enable;
  logic       cfg_valid;
  logic [6:0] cfg_red_dc;
  logic [6:0] cfg_ir_dc;
  logic [3:0] cfg_red_pga;
  logic [3:0] cfg_ir_pga;
  logic [7:0] ADC;
  logic       LED_RED;
  logic       LED_IR;
  logic [6:0] DC_Comp;
  logic [3:0] PGA_Gain;
  logic [7:0] RED_ADC_Value;
  logic [7:0] IR_ADC_Value;
  logic       red_valid;
  logic       ir_valid;
  logic       pair_valid;
  logic       red_sat;
  logic       ir_sat;

  modport master (
    output enable, cfg_valid, cfg_red_dc, cfg_ir_dc, cfg_red_pga, cfg_ir_pga, ADC,
    input  LED_RED, LED_IR, DC_Comp, PGA_Gain, RED_ADC_Value, IR_ADC_Value,
           red_valid, ir_valid, pair_valid, red_sat, ir_sat
  );

  modport slave (
    input  enable, cfg_valid, cfg_red_dc, cfg_ir_dc, cfg_red_pga, cfg_ir_pga, ADC,
    output LED_RED, LED_IR, DC_Comp, PGA_Gain, RED_ADC_Value, IR_ADC_Value,
           red_valid, ir_valid, pair_valid, red_sat, ir_sat
  );
endinterface

// File: rtl/ppg_phase_sequencer.sv
// Alternates RED/IR LED phases, applies per-channel analog settings at phase starts,
// and publishes settled, averaged ADC values with saturation flags.
module ppg_phase_sequencer #(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned AVG_LOG2 = 3
) (
  input logic                  CLK,
  input logic                  rst_n,
  ppg_phase_sequencer_if.slave bus
);

  localparam int unsigned PLEN  = SETTLE + (32'd1 << AVG_LOG2);
  localparam int unsigned PC_W  = (PLEN > 32'd1) ? $clog2(PLEN) : 32'd1;
  localparam int unsigned ACC_W = 32'd8 + AVG_LOG2;
  localparam logic [PC_W-1:0] SETTLE_PC = PC_W'(SETTLE);
  localparam logic [PC_W-1:0] LAST_PC   = PC_W'(PLEN - 32'd1);
  localparam logic [6:0]      DC_IDLE   = 7'd64;
  localparam logic [3:0]      PGA_IDLE  = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RED  = 2'd1,
    ST_IR   = 2'd2
  } state_t;

  // A sample at either converter rail marks the phase as saturated.
  function automatic logic is_rail(input logic [7:0] sample);
    return (sample == 8'd0) || (sample == 8'd255);
  endfunction

  state_t           state_r, state_s;
  logic [PC_W-1:0]  pc_r, pc_s;
  logic [ACC_W-1:0] acc_r, acc_s, sum_s;
  logic             sat_r, sat_s, phase_sat_s;
  logic             red_done_r, red_done_s;
  logic [6:0]       shd_red_dc_r, shd_red_dc_s, shd_ir_dc_r, shd_ir_dc_s;
  logic [3:0]       shd_red_pga_r, shd_red_pga_s, shd_ir_pga_r, shd_ir_pga_s;
  logic [6:0]       dc_r, dc_s;
  logic [3:0]       pga_r, pga_s;
  logic             led_red_r, led_red_s, led_ir_r, led_ir_s;
  logic [7:0]       red_val_r, red_val_s, ir_val_r, ir_val_s, avg_s;
  logic             red_valid_r, red_valid_s, ir_valid_r, ir_valid_s, pair_valid_r, pair_valid_s;
  logic             red_sat_r, red_sat_s, ir_sat_r, ir_sat_s;
  logic             last_s, counted_s;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    acc_s         = acc_r;
    sat_s         = sat_r;
    red_done_s    = red_done_r;
    dc_s          = dc_r;
    pga_s         = pga_r;
    red_val_s     = red_val_r;
    ir_val_s      = ir_val_r;
    red_sat_s     = red_sat_r;
    ir_sat_s      = ir_sat_r;
    red_valid_s   = 1'b0;
    ir_valid_s    = 1'b0;
    pair_valid_s  = 1'b0;
    // A same-edge cfg_valid must already be visible to a phase starting on that edge.
    shd_red_dc_s  = bus.cfg_valid ? bus.cfg_red_dc  : shd_red_dc_r;
    shd_ir_dc_s   = bus.cfg_valid ? bus.cfg_ir_dc   : shd_ir_dc_r;
    shd_red_pga_s = bus.cfg_valid ? bus.cfg_red_pga : shd_red_pga_r;
    shd_ir_pga_s  = bus.cfg_valid ? bus.cfg_ir_pga  : shd_ir_pga_r;
    last_s        = (pc_r == LAST_PC);
    counted_s     = (pc_r >= SETTLE_PC);
    sum_s         = acc_r + ACC_W'(bus.ADC);
    avg_s         = sum_s[ACC_W-1:AVG_LOG2];
    phase_sat_s   = sat_r | is_rail(bus.ADC);

    case (state_r)
      ST_IDLE: begin
        acc_s = {ACC_W{1'b0}};
        sat_s = 1'b0;
        pc_s  = {PC_W{1'b0}};
        if (bus.enable) begin
          state_s = ST_RED;
          dc_s    = shd_red_dc_s;
          pga_s   = shd_red_pga_s;
        end else begin
          dc_s  = DC_IDLE;
          pga_s = PGA_IDLE;
        end
      end
      ST_RED, ST_IR: begin
        if (last_s) begin
          pc_s  = {PC_W{1'b0}};
          acc_s = {ACC_W{1'b0}};
          sat_s = 1'b0;
          if (state_r == ST_RED) begin
            red_val_s   = avg_s;
            red_sat_s   = phase_sat_s;
            red_valid_s = 1'b1;
            red_done_s  = 1'b1;
            state_s     = ST_IR;
            dc_s        = shd_ir_dc_s;
            pga_s       = shd_ir_pga_s;
          end else begin
            ir_val_s     = avg_s;
            ir_sat_s     = phase_sat_s;
            ir_valid_s   = 1'b1;
            pair_valid_s = red_done_r;
            red_done_s   = 1'b0;
            if (bus.enable) begin
              state_s = ST_RED;
              dc_s    = shd_red_dc_s;
              pga_s   = shd_red_pga_s;
            end else begin
              state_s = ST_IDLE;
              dc_s    = DC_IDLE;
              pga_s   = PGA_IDLE;
            end
          end
        end else begin
          pc_s = pc_r + PC_W'(1);
          if (counted_s) begin
            acc_s = sum_s;
            sat_s = phase_sat_s;
          end else begin
            acc_s = acc_r;
            sat_s = sat_r;
          end
        end
      end
      default: begin
        state_s    = ST_IDLE;
        pc_s       = {PC_W{1'b0}};
        acc_s      = {ACC_W{1'b0}};
        sat_s      = 1'b0;
        red_done_s = 1'b0;
        dc_s       = DC_IDLE;
        pga_s      = PGA_IDLE;
      end
    endcase

    led_red_s = (state_s == ST_RED);
    led_ir_s  = (state_s == ST_IR);
  end

  // State, shadow configuration and output registers.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      pc_r          <= {PC_W{1'b0}};
      acc_r         <= {ACC_W{1'b0}};
      sat_r         <= 1'b0;
      red_done_r    <= 1'b0;
      shd_red_dc_r  <= DC_IDLE;
      shd_ir_dc_r   <= DC_IDLE;
      shd_red_pga_r <= PGA_IDLE;
      shd_ir_pga_r  <= PGA_IDLE;
      dc_r          <= DC_IDLE;
      pga_r         <= PGA_IDLE;
      led_red_r     <= 1'b0;
      led_ir_r      <= 1'b0;
      red_val_r     <= 8'd0;
      ir_val_r      <= 8'd0;
      red_valid_r   <= 1'b0;
      ir_valid_r    <= 1'b0;
      pair_valid_r  <= 1'b0;
      red_sat_r     <= 1'b0;
      ir_sat_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      acc_r         <= acc_s;
      sat_r         <= sat_s;
      red_done_r    <= red_done_s;
      shd_red_dc_r  <= shd_red_dc_s;
      shd_ir_dc_r   <= shd_ir_dc_s;
      shd_red_pga_r <= shd_red_pga_s;
      shd_ir_pga_r  <= shd_ir_pga_s;
      dc_r          <= dc_s;
      pga_r         <= pga_s;
      led_red_r     <= led_red_s;
      led_ir_r      <= led_ir_s;
      red_val_r     <= red_val_s;
      ir_val_r      <= ir_val_s;
      red_valid_r   <= red_valid_s;
      ir_valid_r    <= ir_valid_s;
      pair_valid_r  <= pair_valid_s;
      red_sat_r     <= red_sat_s;
      ir_sat_r      <= ir_sat_s;
    end
  end

  assign bus.LED_RED       = led_red_r;
  assign bus.LED_IR        = led_ir_r;
  assign bus.DC_Comp       = dc_r;
  assign bus.PGA_Gain      = pga_r;
  assign bus.RED_ADC_Value = red_val_r;
  assign bus.IR_ADC_Value  = ir_val_r;
  assign bus.red_valid     = red_valid_r;
  assign bus.ir_valid      = ir_valid_r;
  assign bus.pair_valid    = pair_valid_r;
  assign bus.red_sat       = red_sat_r;
  assign bus.ir_sat        = ir_sat_r;

endmodule
